data_mem_responder: RTL and testbench

//   Word-addressed data memory: the responder end of the CPU load/store interface.

---
 rtl/data_mem_responder.sv | 103 ++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering CPU load/store requests over valid/ready
// handshakes, with a configurable number of wait cycles before each response.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [DEPTH];

  logic          access_err;
  logic [AW-1:0] word_idx;

  // Out-of-range addresses are rejected rather than folded back onto low words.
  assign access_err = (lat_addr[1:0] != 2'b00) || (lat_addr >= ADDR_LIMIT);
  assign word_idx   = lat_addr[AW+1:2];

  // The accept cycle itself counts as one wait cycle, so the response appears
  // LATENCY+1 edges after the accept edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            lat_we      <= req_we_i;
            lat_addr    <= req_addr_i;
            lat_wdata   <= req_wdata_i;
            cnt         <= WAIT_INIT;
            req_ready_o <= 1'b0;
            state       <= BUSY;
          end else begin
            req_ready_o <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            if (access_err) begin
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else if (lat_we) begin
              mem[word_idx] <= lat_wdata;
              resp_rdata_o  <= '0;
            end else begin
              resp_rdata_o <= mem[word_idx];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: one instance at LATENCY=2 for the main tests and
// one at LATENCY=0 for the zero-wait timing and streaming rate.
module tb_data_mem_responder;

  localparam int LAT_A = 2;

  logic clk;
  logic rst;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int compared   = 0;
  int mismatched = 0;

  data_mem_responder #(.DEPTH(128), .LATENCY(LAT_A)) dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (a_req_valid),
    .req_ready_o  (a_req_ready),
    .req_we_i     (a_req_we),
    .req_addr_i   (a_req_addr),
    .req_wdata_i  (a_req_wdata),
    .resp_valid_o (a_resp_valid),
    .resp_ready_i (a_resp_ready),
    .resp_rdata_o (a_resp_rdata),
    .resp_err_o   (a_resp_err)
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(0)) dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (b_req_valid),
    .req_ready_o  (b_req_ready),
    .req_we_i     (b_req_we),
    .req_addr_i   (b_req_addr),
    .req_wdata_i  (b_req_wdata),
    .resp_valid_o (b_resp_valid),
    .resp_ready_i (b_resp_ready),
    .resp_rdata_o (b_resp_rdata),
    .resp_err_o   (b_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full request/response on the LATENCY=2 instance, holding off the response for 'hold' cycles.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold,
                               input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_ready"}, {31'd0, a_req_ready}, 32'd1);
    tick();
    a_req_valid = 1'b0;
    checkOutput({tag, "_ackdrop"}, {31'd0, a_req_ready}, 32'd0);
    n = 0;
    while (!a_resp_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(LAT_A + 1));
    checkOutput({tag, "_rdata"}, a_resp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'd0, a_resp_err}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput({tag, "_hold_valid"}, {31'd0, a_resp_valid}, 32'd1);
      checkOutput({tag, "_hold_rdata"}, a_resp_rdata, exp_rdata);
      checkOutput({tag, "_hold_err"}, {31'd0, a_resp_err}, {31'd0, exp_err});
      checkOutput({tag, "_hold_reqrdy"}, {31'd0, a_req_ready}, 32'd0);
    end
    a_resp_ready = 1'b1;
    tick();
    a_resp_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, {31'd0, a_resp_valid}, 32'd0);
    checkOutput({tag, "_done_reqrdy"}, {31'd0, a_req_ready}, 32'd1);
    checkOutput({tag, "_done_rdata"}, a_resp_rdata, 32'd0);
    checkOutput({tag, "_done_err"}, {31'd0, a_resp_err}, 32'd0);
  endtask

  initial begin
    int acc;
    int first_i;
    int last_i;

    rst          = 1'b0;
    a_req_valid  = 1'b0;
    a_req_we     = 1'b0;
    a_req_addr   = '0;
    a_req_wdata  = '0;
    a_resp_ready = 1'b0;
    b_req_valid  = 1'b0;
    b_req_we     = 1'b0;
    b_req_addr   = '0;
    b_req_wdata  = '0;
    b_resp_ready = 1'b0;

    $display("[TB] reset and idle");
    tick(); tick(); tick();
    checkOutput("rst_reqrdy", {31'd0, a_req_ready}, 32'd0);
    checkOutput("rst_valid", {31'd0, a_resp_valid}, 32'd0);
    checkOutput("rst_rdata", a_resp_rdata, 32'd0);
    checkOutput("rst_err", {31'd0, a_resp_err}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("rel_reqrdy", {31'd0, a_req_ready}, 32'd1);
    checkOutput("rel_valid", {31'd0, a_resp_valid}, 32'd0);

    $display("[TB] store then load");
    applyStimulus("st10", 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    applyStimulus("ld10", 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);

    $display("[TB] backpressure");
    applyStimulus("st24", 1'b1, 32'h24, 32'h12345678, 0, 32'h0, 1'b0);
    applyStimulus("ld24bp", 1'b0, 32'h24, 32'h0, 5, 32'h12345678, 1'b0);

    $display("[TB] errors and address boundary");
    applyStimulus("ld13", 1'b0, 32'h13, 32'h0, 0, 32'h0, 1'b1);
    applyStimulus("st200", 1'b1, 32'h200, 32'hCAFEF00D, 0, 32'h0, 1'b1);
    applyStimulus("ld1fc", 1'b0, 32'h1FC, 32'h0, 0, 32'h0, 1'b0);
    applyStimulus("ld000", 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    applyStimulus("st1fc", 1'b1, 32'h1FC, 32'hA5A5A5A5, 0, 32'h0, 1'b0);
    applyStimulus("ld1fc2", 1'b0, 32'h1FC, 32'h0, 0, 32'hA5A5A5A5, 1'b0);
    applyStimulus("ld000b", 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);

    $display("[TB] zero-latency instance");
    b_req_we    = 1'b0;
    b_req_addr  = 32'h8;
    b_req_valid = 1'b1;
    checkOutput("z_reqrdy", {31'd0, b_req_ready}, 32'd1);
    tick();
    b_req_valid = 1'b0;
    checkOutput("z_valid_T", {31'd0, b_resp_valid}, 32'd0);
    tick();
    checkOutput("z_valid_T1", {31'd0, b_resp_valid}, 32'd1);
    checkOutput("z_rdata", b_resp_rdata, 32'd0);
    checkOutput("z_err", {31'd0, b_resp_err}, 32'd0);
    b_resp_ready = 1'b1;
    tick();
    checkOutput("z_done_valid", {31'd0, b_resp_valid}, 32'd0);
    checkOutput("z_done_reqrdy", {31'd0, b_req_ready}, 32'd1);

    b_req_valid = 1'b1;
    acc     = 0;
    first_i = -1;
    last_i  = -1;
    for (int i = 0; i < 12; i++) begin
      if (b_req_ready) begin
        acc++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      tick();
    end
    b_req_valid = 1'b0;
    tick(); tick(); tick();
    b_resp_ready = 1'b0;
    checkOutput("z_stream_accepts", 32'(acc), 32'd4);
    checkOutput("z_stream_span", 32'(last_i - first_i), 32'd9);

    $display("[TB] reset mid-operation");
    a_req_we    = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'h55;
    a_req_valid = 1'b1;
    checkOutput("mid_reqrdy", {31'd0, a_req_ready}, 32'd1);
    tick();
    a_req_valid = 1'b0;
    tick();
    checkOutput("mid_busy_valid", {31'd0, a_resp_valid}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("mid_rst_valid", {31'd0, a_resp_valid}, 32'd0);
    checkOutput("mid_rst_reqrdy", {31'd0, a_req_ready}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("mid_rel_valid", {31'd0, a_resp_valid}, 32'd0);
    applyStimulus("ld20", 1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0);
    applyStimulus("ld10rst", 1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
